// File: rtl/pkt_fork_n_avlstrm_pkg.sv
// Shared types for the N-way Avalon-ST packet fork: FSM states, packet metadata
// and statistics counter width.
package pkt_fork_n_avlstrm_pkg;

  localparam int STATS_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } fork_state_e;

  typedef struct packed {
    logic sop;
    logic eop;
  } metadata_t;

  // Counters wrap naturally modulo 2^STATS_W.
  function automatic logic [STATS_W-1:0] stat_inc(input logic [STATS_W-1:0] v, input logic en);
    return en ? (v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/avl_skid_buf.sv
// Two-entry (main + skid) ready/valid buffer with registered input ready.
// The payload is opaque; callers pack data plus any routing tag into it.
module avl_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          ready_nxt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] main_data_q, main_data_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          in_ready_q;
  logic          push, pop;

  // Next-state of the two entries; the skid only fills while main is stalled.
  always_comb begin
    push         = in_valid && in_ready_q;
    pop          = main_valid_q && out_ready;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      if (pop) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_data_d = main_data_q;
      end
    end else if (!main_valid_q || pop) begin
      main_valid_d = push;
      if (push) begin
        main_data_d = in_data;
      end else begin
        main_data_d = main_data_q;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end else begin
      skid_valid_d = 1'b0;
    end
    ready_nxt = !skid_valid_d;
  end

  // Entry registers and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= ready_nxt;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/pkt_fork_n_avlstrm.sv
// N-way Avalon-ST packet fork: routes whole packets to the channel chosen on SOP,
// optionally drops out-of-range destinations, and keeps per-channel statistics.
module pkt_fork_n_avlstrm
  import pkt_fork_n_avlstrm_pkg::*;
#(
  parameter int WIDTH   = 512,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = $clog2(NUM_OUT),
  parameter int DROP_EN = 1,
  parameter int EMPTY_W = $clog2(WIDTH/8)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic [EMPTY_W-1:0]         in_empty,
  input  logic [SEL_W:0]             in_sel,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [EMPTY_W-1:0]         out_empty,
  output logic [NUM_OUT-1:0]         out_valid,
  input  logic [NUM_OUT-1:0]         out_ready,
  output logic [NUM_OUT*STATS_W-1:0] stats_out_pkt,
  output logic [STATS_W-1:0]         stats_drop_pkt,
  output logic [STATS_W-1:0]         stats_err
);

  localparam int META_W = $bits(metadata_t);
  localparam int BUF_W  = SEL_W + META_W + EMPTY_W + WIDTH;

  fork_state_e state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic in_ready_q, in_ready_d;
  logic accept, in_range, push, err_inc, drop_inc;
  metadata_t push_meta;

  logic [NUM_OUT-1:0][STATS_W-1:0] stats_out_q, stats_out_d;
  logic [STATS_W-1:0] stats_drop_q, stats_drop_d;
  logic [STATS_W-1:0] stats_err_q, stats_err_d;

  logic             buf_ready_nxt, buf_out_valid, emit;
  logic [BUF_W-1:0] buf_in_data, buf_out_data;
  logic [SEL_W-1:0] out_tag;
  metadata_t        out_meta;

  // Packet FSM: picks the destination on SOP and classifies each accepted beat.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    push      = 1'b0;
    err_inc   = 1'b0;
    drop_inc  = 1'b0;
    accept    = in_valid && in_ready_q;
    in_range  = (in_sel < (SEL_W+1)'(NUM_OUT));
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_sop) begin
            if (in_range || (DROP_EN == 0)) begin
              sel_d   = in_range ? in_sel[SEL_W-1:0] : SEL_W'(NUM_OUT - 1);
              push    = 1'b1;
              state_d = in_eop ? ST_IDLE : ST_FWD;
            end else begin
              drop_inc = in_eop;
              state_d  = in_eop ? ST_IDLE : ST_DROP;
            end
          end else begin
            err_inc = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (accept) begin
          push    = 1'b1;
          err_inc = in_sop;
          state_d = in_eop ? ST_IDLE : ST_FWD;
        end else begin
          state_d = ST_FWD;
        end
      end
      ST_DROP: begin
        if (accept) begin
          err_inc  = in_sop;
          drop_inc = in_eop;
          state_d  = in_eop ? ST_IDLE : ST_DROP;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A stray SOP inside a packet is forwarded as a plain continuation beat.
    push_meta.sop = (state_q == ST_IDLE);
    push_meta.eop = in_eop;
    in_ready_d    = (state_d == ST_DROP) || buf_ready_nxt;
  end

  assign buf_in_data = {sel_d, push_meta, in_empty, in_data};

  avl_skid_buf #(
    .DW(BUF_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (push),
    .in_data  (buf_in_data),
    .ready_nxt(buf_ready_nxt),
    .out_valid(buf_out_valid),
    .out_ready(out_ready[out_tag]),
    .out_data (buf_out_data)
  );

  assign {out_tag, out_meta, out_empty, out_data} = buf_out_data;
  assign out_sop = out_meta.sop;
  assign out_eop = out_meta.eop;
  assign emit    = buf_out_valid && out_ready[out_tag];

  // Channel valid decode and statistics next-state.
  always_comb begin
    for (int c = 0; c < NUM_OUT; c++) begin
      out_valid[c]   = buf_out_valid && (out_tag == SEL_W'(c));
      stats_out_d[c] = stat_inc(stats_out_q[c], emit && out_eop && (out_tag == SEL_W'(c)));
    end
    stats_drop_d = stat_inc(stats_drop_q, drop_inc);
    stats_err_d  = stat_inc(stats_err_q, err_inc);
  end

  // Control, ready and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      in_ready_q   <= 1'b0;
      stats_out_q  <= '0;
      stats_drop_q <= '0;
      stats_err_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      in_ready_q   <= in_ready_d;
      stats_out_q  <= stats_out_d;
      stats_drop_q <= stats_drop_d;
      stats_err_q  <= stats_err_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign stats_out_pkt  = stats_out_q;
  assign stats_drop_pkt = stats_drop_q;
  assign stats_err      = stats_err_q;

endmodule

// File: doc/pkt_fork_n_avlstrm.md
PKT_FORK_N_AVLSTRM -- requirements
Module: pkt_fork_n_avlstrm

Interface
REQ-001 Param WIDTH, 512, packet data width in bits.
REQ-002 Param NUM_OUT, 4, number of output channels (2..16).
REQ-003 Param SEL_W, $clog2(NUM_OUT), selector width.
REQ-004 Param DROP_EN, 1, 1 = drop packets with out-of-range selector; 0 = route them to channel NUM_OUT-1.
REQ-005 Clk  in  1  sole clock; all logic on rising edge.
REQ-006 Rst  in  1  asynchronous active-high reset.
REQ-007 in_data/in_valid/in_ready/in_sop/in_eop/in_empty  in,in,out,in,in,in  WIDTH,1,1,1,1,$clog2(WIDTH/8)  Avalon-ST packet input.
REQ-008 in_sel  in  SEL_W+1  destination channel, sampled only on accepted SOP beat.
REQ-009 out_data/out_sop/out_eop/out_empty  out  WIDTH,1,1,$clog2(WIDTH/8)  shared output payload, valid on any channel.
REQ-010 out_valid / out_ready  out / in  NUM_OUT each  per-channel handshake.
REQ-011 stats_out_pkt  out  NUM_OUT x 32  packets completed (EOP accepted) per channel.
REQ-012 stats_drop_pkt / stats_err  out  32 each  dropped packets / protocol errors.

Function
REQ-013 A beat SHALL be accepted when in_valid && in_ready; emitted on channel c when out_valid[c] && out_ready[c].
REQ-014 FSM SHALL have states IDLE, FWD, DROP; reset state IDLE.
REQ-015 IDLE: accepted SOP beat with in_sel < NUM_OUT latches sel, enters FWD (or stays IDLE if same beat has EOP).
REQ-016 IDLE: accepted SOP with in_sel >= NUM_OUT enters DROP if DROP_EN=1, else FWD with sel = NUM_OUT-1.
REQ-017 IDLE: accepted beat without SOP SHALL be discarded, stats_err +1, state unchanged.
REQ-018 FWD/DROP: latched sel SHALL hold until the EOP beat is accepted, then return to IDLE.
REQ-019 FWD/DROP: SOP mid-packet SHALL be treated as continuation (sel unchanged), stats_err +1.
REQ-020 DROP: in_ready SHALL be 1; beats discarded; stats_drop_pkt +1 on EOP accept.
REQ-021 Output stage SHALL be a 2-entry skid buffer (main + skid) tagged with channel; latency 1 cycle; full throughput, no bubbles under continuous ready.
REQ-022 in_ready SHALL be registered: 0 only while skid entry occupied (except DROP/IDLE-discard paths, which never stall).
REQ-023 out_valid[c] SHALL be 1 only for c = tag of main entry; at most one bit set (one-hot or zero).
REQ-024 out_ready of non-selected channels SHALL be ignored; no beat reordering; no cross-channel interleave within a packet.
REQ-025 stats_out_pkt[c] SHALL increment on EOP emitted on channel c; all counters wrap modulo 2^32.
REQ-026 Simultaneous err and drop events in one cycle SHALL both count.
REQ-027 Single-beat packet (SOP&&EOP) SHALL be handled in IDLE without state change.

Reset
REQ-028 Rst assertion SHALL asynchronously clear FSM to IDLE, both buffer entries invalid, out_valid=0, in_ready=0, all stats=0.
REQ-029 in_ready SHALL rise the first cycle after Rst deasserts; partial packets in flight at reset are lost, not completed.

Structure
REQ-030 State enum and stats-width constant SHALL live in the shared struct package alongside metadata_t.
REQ-031 Skid buffer SHALL be one sub-module, avl_skid_buf, parametrised on WIDTH+tag width.
REQ-032 Block SHALL be drop-in for the existing 2-way fork when NUM_OUT=2, DROP_EN=0.

Verification
REQ-033 3-beat pkt sel=2, all ready=1 -> beats on out_valid[2] at cycles t+1..t+3, stats_out_pkt[2]=1.
REQ-034 sel=5, NUM_OUT=4, DROP_EN=1, 4-beat pkt -> no out_valid, in_ready stays 1, stats_drop_pkt=1.
REQ-035 Back-to-back pkts sel=0 then sel=1, out_ready[0]=0 for 5 cycles -> in_ready drops after 2 beats buffered; pkt1 never precedes pkt0 tail.
REQ-036 Non-SOP beat in IDLE, then SOP mid-packet -> stats_err=2, packet emitted intact on latched channel.
REQ-037 Rst pulse mid 8-beat packet after beat 3 -> all outputs 0, stats 0; next SOP routes normally.
REQ-038 Random sel/ready, 10k pkts -> per-channel scoreboard match, sum of stats_out_pkt + stats_drop_pkt = pkts sent.
